// File: rtl/bus_pkg.sv
// Shared types and constants for the byte-serial bus initiator.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 64;
    localparam int unsigned BUS_DATA_W = 8;

    // Request size encoding: bytes = 1 << size.
    typedef enum logic [1:0] {
        Size1B = 2'd0,
        Size2B = 2'd1,
        Size4B = 2'd2,
        Size8B = 2'd3
    } req_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } state_e;

    // Number of bytes moved for a given request size.
    function automatic logic [3:0] size_to_bytes(req_size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Core-request, response and byte-bus signals of the bus initiator.
interface bus_initiator_if;
    import bus_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic [BUS_ADDR_W-1:0] req_addr;
    logic [63:0]           req_wdata;
    logic                  resp_valid;
    logic [63:0]           resp_rdata;
    logic                  bus_we;
    logic [BUS_ADDR_W-1:0] bus_addr;
    logic [BUS_DATA_W-1:0] bus_data_out;
    logic [BUS_DATA_W-1:0] bus_data_in;

    // The initiator itself.
    modport master (
        input  req_valid, req_we, req_size, req_addr, req_wdata, bus_data_in,
        output req_ready, resp_valid, resp_rdata, bus_we, bus_addr, bus_data_out
    );

    // The core and bus controller around it.
    modport slave (
        output req_valid, req_we, req_size, req_addr, req_wdata, bus_data_in,
        input  req_ready, resp_valid, resp_rdata, bus_we, bus_addr, bus_data_out
    );

endinterface

// File: rtl/bus_initiator.sv
// Splits a 1/2/4/8-byte core request into single-byte bus accesses and
// returns one completion pulse. READ_LAT (1..8) is the hold time per read byte.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int unsigned READ_LAT = 2
) (
    input  logic     clk,
    input  logic     reset,
    bus_initiator_if.master bus
);

    localparam logic [2:0] LastLat = 3'(READ_LAT - 1);

    state_e                state_q, state_d;
    logic [BUS_ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [63:0]           rdata_q, rdata_d;
    logic [3:0]            nbytes_q, nbytes_d;
    logic [3:0]            idx_q, idx_d;
    logic [2:0]            lat_q, lat_d;

    // Output registers, loaded with values derived from the next state.
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [63:0]           resp_rdata_q, resp_rdata_d;
    logic                  bus_we_q, bus_we_d;
    logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [BUS_DATA_W-1:0] bus_dout_q, bus_dout_d;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        nbytes_d = nbytes_q;
        idx_d    = idx_q;
        lat_d    = lat_q;

        case (state_q)
            StIdle: begin
                // ready_q gates acceptance, so the first cycle after reset ignores requests.
                if (bus.req_valid && ready_q) begin
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    nbytes_d = size_to_bytes(req_size_e'(bus.req_size));
                    idx_d    = '0;
                    lat_d    = '0;
                    state_d  = bus.req_we ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (idx_q == nbytes_q - 4'd1) begin
                    state_d = StResp;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StRead: begin
                if (lat_q == LastLat) begin
                    rdata_d[{idx_q[2:0], 3'b000} +: 8] = bus.bus_data_in;
                    lat_d = '0;
                    if (idx_q == nbytes_q - 4'd1) begin
                        state_d = StResp;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d      = (state_d == StIdle);
        resp_valid_d = (state_d == StResp);
        resp_rdata_d = (state_d == StResp) ? rdata_d : '0;
        bus_we_d     = (state_d == StWrite);
        bus_addr_d   = (state_d == StWrite || state_d == StRead) ?
                       addr_d + {60'd0, idx_d} : '0;
        bus_dout_d   = (state_d == StWrite) ? wdata_d[{idx_d[2:0], 3'b000} +: 8] : '0;
    end

    // State, counters and outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            nbytes_q     <= '0;
            idx_q        <= '0;
            lat_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            nbytes_q     <= nbytes_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_dout_q   <= bus_dout_d;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.bus_we       = bus_we_q;
    assign bus.bus_addr     = bus_addr_q;
    assign bus.bus_data_out = bus_dout_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed testbench for bus_initiator (READ_LAT=2 main instance, READ_LAT=1 second).
module tb_bus_initiator;

    logic clk = 1'b0;
    logic reset;

    bus_initiator_if bif ();
    bus_initiator_if bif1 ();

    bus_initiator #(.READ_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    bus_initiator #(.READ_LAT(1)) dut_lat1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif1.master)
    );

    always #5 clk = ~clk;

    // Memory model: byte at 0x20+k reads as 0xA0+k.
    assign bif.bus_data_in  = 8'hA0 + (bif.bus_addr[7:0] - 8'h20);
    assign bif1.bus_data_in = 8'h5A;

    int nchk;
    int nbad;

    // Per-cycle log of one transaction (index = cycles after acceptance).
    logic        cyc_we   [0:47];
    logic [63:0] cyc_addr [0:47];
    logic [7:0]  cyc_dout [0:47];
    int          resp_cyc;
    logic [63:0] resp_data;
    logic        post_resp_valid;
    int          busy_ready;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the main instance and log until its response.
    task automatic run_req(input logic we, input logic [1:0] size,
                           input logic [63:0] addr, input logic [63:0] wdata);
        int guard;
        guard = 0;
        while (bif.req_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_size  = size;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        tick();
        bif.req_valid = 1'b0;
        resp_cyc        = -1;
        resp_data       = '0;
        post_resp_valid = 1'b0;
        busy_ready      = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc_we[c]   = bif.bus_we;
            cyc_addr[c] = bif.bus_addr;
            cyc_dout[c] = bif.bus_data_out;
            if (bif.req_ready === 1'b1) busy_ready++;
            if (bif.resp_valid === 1'b1) begin
                resp_cyc  = c;
                resp_data = bif.resp_rdata;
                tick();
                post_resp_valid = bif.resp_valid;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        nchk++; if (bif.req_ready !== 1'b0) begin nbad++; $display("FAIL reset_ready: got %b want 0", bif.req_ready); end
        nchk++; if (bif.resp_valid !== 1'b0) begin nbad++; $display("FAIL reset_resp_valid: got %b want 0", bif.resp_valid); end
        nchk++; if (bif.resp_rdata !== 64'h0) begin nbad++; $display("FAIL reset_rdata: got %h want 0", bif.resp_rdata); end
        nchk++; if (bif.bus_we !== 1'b0) begin nbad++; $display("FAIL reset_bus_we: got %b want 0", bif.bus_we); end
        nchk++; if (bif.bus_addr !== 64'h0) begin nbad++; $display("FAIL reset_bus_addr: got %h want 0", bif.bus_addr); end
        nchk++; if (bif.bus_data_out !== 8'h0) begin nbad++; $display("FAIL reset_bus_dout: got %h want 0", bif.bus_data_out); end
        reset = 1'b0;
        nchk++; if (bif.req_ready !== 1'b0) begin nbad++; $display("FAIL ready_at_release: got %b want 0", bif.req_ready); end
        tick();
        nchk++; if (bif.req_ready !== 1'b1) begin nbad++; $display("FAIL ready_after_release: got %b want 1", bif.req_ready); end
        nchk++; if (bif1.req_ready !== 1'b1) begin nbad++; $display("FAIL lat1_ready_after_release: got %b want 1", bif1.req_ready); end
    endtask

    task automatic test_store_dword;
        logic [63:0] ea;
        logic [7:0]  ed;
        run_req(1'b1, 2'd3, 64'h1000, 64'h8877665544332211);
        nchk++; if (resp_cyc != 9) begin nbad++; $display("FAIL st8_latency: got %0d want 9", resp_cyc); end
        nchk++; if (resp_data !== 64'h0) begin nbad++; $display("FAIL st8_rdata: got %h want 0", resp_data); end
        nchk++; if (post_resp_valid !== 1'b0) begin nbad++; $display("FAIL st8_pulse_width: got %b want 0", post_resp_valid); end
        nchk++; if (busy_ready != 0) begin nbad++; $display("FAIL st8_ready_busy: got %0d want 0", busy_ready); end
        for (int i = 0; i < 8; i++) begin
            ea = 64'h1000 + 64'(i);
            ed = 8'(8'h11 * (i + 1));
            nchk++;
            if (cyc_we[i+1] !== 1'b1 || cyc_addr[i+1] !== ea || cyc_dout[i+1] !== ed) begin
                nbad++;
                $display("FAIL st8_byte%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                         i, cyc_we[i+1], cyc_addr[i+1], cyc_dout[i+1], ea, ed);
            end
        end
        nchk++;
        if (cyc_we[9] !== 1'b0 || cyc_addr[9] !== 64'h0 || cyc_dout[9] !== 8'h0) begin
            nbad++;
            $display("FAIL st8_resp_bus_idle: got we=%b a=%h d=%h want 0 0 0",
                     cyc_we[9], cyc_addr[9], cyc_dout[9]);
        end
    endtask

    task automatic test_load_word;
        logic [63:0] ea;
        run_req(1'b0, 2'd2, 64'h20, 64'h0);
        nchk++; if (resp_cyc != 9) begin nbad++; $display("FAIL ld4_latency: got %0d want 9", resp_cyc); end
        nchk++; if (resp_data !== 64'h00000000A3A2A1A0) begin nbad++; $display("FAIL ld4_rdata: got %h want 00000000a3a2a1a0", resp_data); end
        for (int c = 1; c <= 8; c++) begin
            ea = 64'h20 + 64'((c - 1) / 2);
            nchk++;
            if (cyc_we[c] !== 1'b0 || cyc_addr[c] !== ea || cyc_dout[c] !== 8'h0) begin
                nbad++;
                $display("FAIL ld4_cycle%0d: got we=%b a=%h d=%h want we=0 a=%h d=0",
                         c, cyc_we[c], cyc_addr[c], cyc_dout[c], ea);
            end
        end
    endtask

    task automatic test_unaligned_load;
        run_req(1'b0, 2'd1, 64'h23, 64'h0);
        nchk++; if (resp_cyc != 5) begin nbad++; $display("FAIL ld2u_latency: got %0d want 5", resp_cyc); end
        nchk++; if (resp_data !== 64'h000000000000A4A3) begin nbad++; $display("FAIL ld2u_rdata: got %h want a4a3", resp_data); end
    endtask

    task automatic test_store_wrap;
        run_req(1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBEEF);
        nchk++; if (resp_cyc != 3) begin nbad++; $display("FAIL wrap_latency: got %0d want 3", resp_cyc); end
        nchk++;
        if (cyc_we[1] !== 1'b1 || cyc_addr[1] !== 64'hFFFF_FFFF_FFFF_FFFF || cyc_dout[1] !== 8'hEF) begin
            nbad++;
            $display("FAIL wrap_byte0: got we=%b a=%h d=%h want we=1 a=ffffffffffffffff d=ef",
                     cyc_we[1], cyc_addr[1], cyc_dout[1]);
        end
        nchk++;
        if (cyc_we[2] !== 1'b1 || cyc_addr[2] !== 64'h0 || cyc_dout[2] !== 8'hBE) begin
            nbad++;
            $display("FAIL wrap_byte1: got we=%b a=%h d=%h want we=1 a=0 d=be",
                     cyc_we[2], cyc_addr[2], cyc_dout[2]);
        end
    endtask

    task automatic test_back_to_back;
        logic        t_we   [0:3];
        logic [1:0]  t_size [0:3];
        logic [63:0] t_addr [0:3];
        logic [63:0] t_wd   [0:3];
        logic [63:0] t_exp  [0:3];
        int   k, nresp, nwe, dup, bad_ready;
        logic prev_resp, acc;
        t_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
        t_size = '{2'd0, 2'd1, 2'd1, 2'd0};
        t_addr = '{64'h40, 64'h21, 64'h50, 64'h2F};
        t_wd   = '{64'h77, 64'h0, 64'h1234, 64'h0};
        t_exp  = '{64'h0, 64'hA2A1, 64'h0, 64'hAF};
        k = 0; nresp = 0; nwe = 0; dup = 0; bad_ready = 0; prev_resp = 1'b0;
        bif.req_valid = 1'b1;
        bif.req_we    = t_we[0];
        bif.req_size  = t_size[0];
        bif.req_addr  = t_addr[0];
        bif.req_wdata = t_wd[0];
        for (int c = 0; c < 200 && nresp < 4; c++) begin
            acc = (bif.req_ready === 1'b1) && (bif.req_valid === 1'b1);
            tick();
            if (bif.bus_we === 1'b1) nwe++;
            if (bif.resp_valid === 1'b1) begin
                if (nresp < 4) begin
                    nchk++;
                    if (bif.resp_rdata !== t_exp[nresp]) begin
                        nbad++;
                        $display("FAIL b2b_rdata%0d: got %h want %h", nresp, bif.resp_rdata, t_exp[nresp]);
                    end
                end
                nresp++;
                if (prev_resp) dup++;
                if (bif.req_ready === 1'b1) bad_ready++;
            end
            prev_resp = bif.resp_valid;
            if (acc) begin
                if (bif.req_ready !== 1'b0) bad_ready++;
                k++;
                if (k < 4) begin
                    bif.req_we    = t_we[k];
                    bif.req_size  = t_size[k];
                    bif.req_addr  = t_addr[k];
                    bif.req_wdata = t_wd[k];
                end else begin
                    bif.req_valid = 1'b0;
                end
            end
        end
        bif.req_valid = 1'b0;
        tick();
        nchk++; if (bif.resp_valid !== 1'b0) begin nbad++; $display("FAIL b2b_last_pulse: got %b want 0", bif.resp_valid); end
        nchk++; if (nresp != 4) begin nbad++; $display("FAIL b2b_resp_count: got %0d want 4", nresp); end
        nchk++; if (k != 4) begin nbad++; $display("FAIL b2b_accept_count: got %0d want 4", k); end
        nchk++; if (nwe != 3) begin nbad++; $display("FAIL b2b_write_cycles: got %0d want 3", nwe); end
        nchk++; if (dup != 0) begin nbad++; $display("FAIL b2b_long_pulse: got %0d want 0", dup); end
        nchk++; if (bad_ready != 0) begin nbad++; $display("FAIL b2b_ready_busy: got %0d want 0", bad_ready); end
    endtask

    task automatic test_reset_abort;
        int nresp, nwe;
        // Load of 8 bytes, reset on the first cycle of byte 2.
        bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_size = 2'd3;
        bif.req_addr = 64'h20; bif.req_wdata = 64'h0;
        tick();
        bif.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        nchk++; if (bif.bus_addr !== 64'h22) begin nbad++; $display("FAIL abort_ld_byte2: got %h want 22", bif.bus_addr); end
        reset = 1'b1;
        tick();
        nchk++;
        if (bif.resp_valid !== 1'b0 || bif.resp_rdata !== 64'h0 || bif.bus_we !== 1'b0 ||
            bif.bus_addr !== 64'h0 || bif.bus_data_out !== 8'h0 || bif.req_ready !== 1'b0) begin
            nbad++;
            $display("FAIL abort_ld_outputs: got rv=%b rd=%h we=%b a=%h d=%h rdy=%b want all 0",
                     bif.resp_valid, bif.resp_rdata, bif.bus_we, bif.bus_addr,
                     bif.bus_data_out, bif.req_ready);
        end
        reset = 1'b0;
        tick();
        nchk++; if (bif.req_ready !== 1'b1) begin nbad++; $display("FAIL abort_ld_ready: got %b want 1", bif.req_ready); end
        nresp = 0;
        for (int i = 0; i < 30; i++) begin
            if (bif.resp_valid === 1'b1) nresp++;
            tick();
        end
        nchk++; if (nresp != 0) begin nbad++; $display("FAIL abort_ld_no_resp: got %0d want 0", nresp); end

        // Store of 8 bytes, reset during byte 2.
        bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_size = 2'd3;
        bif.req_addr = 64'h100; bif.req_wdata = 64'h0807060504030201;
        tick();
        bif.req_valid = 1'b0;
        tick();
        tick();
        nchk++;
        if (bif.bus_we !== 1'b1 || bif.bus_data_out !== 8'h03) begin
            nbad++;
            $display("FAIL abort_st_byte2: got we=%b d=%h want we=1 d=03", bif.bus_we, bif.bus_data_out);
        end
        reset = 1'b1;
        tick();
        nchk++;
        if (bif.bus_we !== 1'b0 || bif.bus_addr !== 64'h0 || bif.bus_data_out !== 8'h0) begin
            nbad++;
            $display("FAIL abort_st_bus: got we=%b a=%h d=%h want 0 0 0",
                     bif.bus_we, bif.bus_addr, bif.bus_data_out);
        end
        reset = 1'b0;
        nresp = 0; nwe = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bif.resp_valid === 1'b1) nresp++;
            if (bif.bus_we === 1'b1) nwe++;
        end
        nchk++;
        if (nresp != 0 || nwe != 0) begin
            nbad++;
            $display("FAIL abort_st_quiet: got resp=%0d we=%0d want 0 0", nresp, nwe);
        end
    endtask

    task automatic test_lat1;
        bif1.req_valid = 1'b1; bif1.req_we = 1'b0; bif1.req_size = 2'd0;
        bif1.req_addr = 64'h7; bif1.req_wdata = 64'h0;
        tick();
        bif1.req_valid = 1'b0;
        nchk++;
        if (bif1.bus_we !== 1'b0 || bif1.bus_addr !== 64'h7 || bif1.resp_valid !== 1'b0) begin
            nbad++;
            $display("FAIL lat1_cycle1: got we=%b a=%h rv=%b want we=0 a=7 rv=0",
                     bif1.bus_we, bif1.bus_addr, bif1.resp_valid);
        end
        tick();
        nchk++; if (bif1.resp_valid !== 1'b1) begin nbad++; $display("FAIL lat1_resp_valid: got %b want 1", bif1.resp_valid); end
        nchk++; if (bif1.resp_rdata !== 64'h5A) begin nbad++; $display("FAIL lat1_rdata: got %h want 5a", bif1.resp_rdata); end
        tick();
        nchk++; if (bif1.resp_valid !== 1'b0) begin nbad++; $display("FAIL lat1_pulse_width: got %b want 0", bif1.resp_valid); end
    endtask

    initial begin
        nchk = 0;
        nbad = 0;
        reset = 1'b1;
        bif.req_valid  = 1'b0; bif.req_we  = 1'b0; bif.req_size  = 2'd0;
        bif.req_addr   = '0;   bif.req_wdata = '0;
        bif1.req_valid = 1'b0; bif1.req_we = 1'b0; bif1.req_size = 2'd0;
        bif1.req_addr  = '0;   bif1.req_wdata = '0;
        test_reset();
        test_store_dword();
        test_load_word();
        test_unaligned_load();
        test_store_wrap();
        test_back_to_back();
        test_reset_abort();
        test_lat1();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
